// File: rtl/sprite_anim_sequencer.sv
// sprite_anim_sequencer: per-frame walk animation sequencer for the VGA color mapper.
// Advances the facing and walk phase on each rising edge of VS, paces the phase
// with a frame divider, emits a registered sprite ROM base address and pulses
// Step_Done once per completed walk cycle.
// Optional feature: define ANIM_TURN_PAUSE_EN to hold the character in place
// for TURN_TICKS frames after every turn (Turn_Hold reports the hold).
module sprite_anim_sequencer #(
    parameter int FRAMES_PER_PHASE = 4,
    parameter int SPRITE_WORDS     = 408,
    parameter int ADDR_W           = 13,
    parameter int TURN_TICKS       = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              VS,
    input  logic              Character_Moving,
    input  logic [1:0]        Direction,
    output logic [1:0]        Facing,
    output logic [1:0]        Phase,
    output logic [ADDR_W-1:0] Sprite_Base,
    output logic              Step_Done,
    output logic              Turn_Hold
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_PHASE - 1);

    // Reject configurations the counters or the address bus cannot represent.
    if (FRAMES_PER_PHASE < 1 || FRAMES_PER_PHASE > 255 ||
        TURN_TICKS < 1 || TURN_TICKS > 255 ||
        ADDR_W < 1 || ADDR_W > 32) begin : g_cfg_check
        $error("sprite_anim_sequencer: parameter out of range");
    end

    logic              vs_q;
    logic              tick;
    logic [1:0]        facing_q, facing_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              step_done_q, step_done_d;
    logic [ADDR_W-1:0] sprite_base_q, sprite_base_d;
    logic [31:0]       sprite_prod;

`ifdef ANIM_TURN_PAUSE_EN
    localparam logic [7:0] HCNT_RELOAD = 8'(TURN_TICKS - 1);
    logic       turn_hold_q, turn_hold_d;
    logic [7:0] hcnt_q, hcnt_d;
`endif

    // One tick per frame: VS is high now but was low on the previous cycle.
    assign tick = VS & ~vs_q;

    // ROM base for the frame currently shown; the full-width product is truncated to the bus.
    always_comb begin
        sprite_prod   = 32'({facing_q, phase_q}) * 32'(SPRITE_WORDS);
        sprite_base_d = sprite_prod[ADDR_W-1:0];
    end

    // Per-tick animation rules: stop, turn, or advance the walk phase via the frame divider.
    always_comb begin
        facing_d    = facing_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        step_done_d = 1'b0;
`ifdef ANIM_TURN_PAUSE_EN
        turn_hold_d = turn_hold_q;
        hcnt_d      = hcnt_q;
`endif
        if (tick) begin
`ifdef ANIM_TURN_PAUSE_EN
            if (turn_hold_q) begin
                // Standing still after a turn; only a fresh turn restarts the hold.
                phase_d = 2'd0;
                cnt_d   = 8'd0;
                if (Character_Moving && (Direction != facing_q)) begin
                    facing_d = Direction;
                    hcnt_d   = HCNT_RELOAD;
                end else if (hcnt_q == 8'd0) begin
                    turn_hold_d = 1'b0;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end else
`endif
            if (!Character_Moving) begin
                phase_d = 2'd0;
                cnt_d   = 8'd0;
            end else if (Direction != facing_q) begin
                facing_d = Direction;
                phase_d  = 2'd0;
                cnt_d    = 8'd0;
`ifdef ANIM_TURN_PAUSE_EN
                turn_hold_d = 1'b1;
                hcnt_d      = HCNT_RELOAD;
`endif
            end else if (cnt_q == CNT_LAST) begin
                cnt_d       = 8'd0;
                phase_d     = phase_q + 2'd1;
                step_done_d = (phase_q == 2'd3);
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers; vs_q resets high so VS already high at release is not a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q          <= 1'b1;
            facing_q      <= 2'd0;
            phase_q       <= 2'd0;
            cnt_q         <= 8'd0;
            step_done_q   <= 1'b0;
            sprite_base_q <= '0;
        end else begin
            vs_q          <= VS;
            facing_q      <= facing_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            step_done_q   <= step_done_d;
            sprite_base_q <= sprite_base_d;
        end
    end

`ifdef ANIM_TURN_PAUSE_EN
    // Turn-in-place hold flag and its remaining-tick counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            turn_hold_q <= 1'b0;
            hcnt_q      <= 8'd0;
        end else begin
            turn_hold_q <= turn_hold_d;
            hcnt_q      <= hcnt_d;
        end
    end

    assign Turn_Hold = turn_hold_q;
`else
    assign Turn_Hold = 1'b0;
`endif

    assign Facing      = facing_q;
    assign Phase       = phase_q;
    assign Sprite_Base = sprite_base_q;
    assign Step_Done   = step_done_q;

endmodule
